// File: rtl/pixel_write_arbiter.sv
// Single-port pixel write arbiter for the VGA adapter: round-robin over three
// requesters plus a full-screen clear sweep that owns the port while running.

module pixel_write_arbiter_lane #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic [7:0] x,
  input  logic [6:0] y,
  output logic       oob
);
  localparam logic [8:0] X_LIM = 9'(WIDTH);
  localparam logic [7:0] Y_LIM = 8'(HEIGHT);

  assign oob = ({1'b0, x} >= X_LIM) | ({1'b0, y} >= Y_LIM);
endmodule

module pixel_write_arbiter #(
  parameter int         WIDTH        = 160,
  parameter int         HEIGHT       = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_req,
  output logic        clear_busy,
  input  logic [2:0]  req_valid,
  input  logic [23:0] req_x,
  input  logic [20:0] req_y,
  input  logic [8:0]  req_colour,
  output logic [2:0]  req_ready,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        oob_err
);
  localparam int         NUM_REQ = 3;
  localparam logic [7:0] X_LAST  = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST  = 7'(HEIGHT - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nxt;

  logic [NUM_REQ-1:0][7:0] lane_x;
  logic [NUM_REQ-1:0][6:0] lane_y;
  logic [NUM_REQ-1:0][2:0] lane_c;
  logic [NUM_REQ-1:0]      lane_oob;

  assign lane_x = req_x;
  assign lane_y = req_y;
  assign lane_c = req_colour;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    pixel_write_arbiter_lane #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_lane (
      .x   (lane_x[i]),
      .y   (lane_y[i]),
      .oob (lane_oob[i])
    );
  end

  logic [1:0] rr_ptr;
  logic [1:0] gidx;
  logic [2:0] grant;
  logic       found;
  int         idx;
  logic [7:0] sweep_x;
  logic [6:0] sweep_y;
  logic       sweep_last;

  assign sweep_last = (sweep_x == X_LAST) && (sweep_y == Y_LAST);
  assign clear_busy = (state == CLEAR);
  assign req_ready  = grant;

  // Search starts one past the last winner; clear requests and reset mask all grants.
  always_comb begin
    grant = '0;
    gidx  = 2'd0;
    found = 1'b0;
    idx   = 0;
    if (reset_n && state == IDLE && !clear_req) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = 2'(idx);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear_req) state_nxt = CLEAR;
      CLEAR:   if (sweep_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      oob_err    <= 1'b0;
      rr_ptr     <= 2'd2;
      sweep_x    <= '0;
      sweep_y    <= '0;
    end else if (state == IDLE && clear_req) begin
      // Pixel (0,0) goes out on the request edge, so the sweep resumes at (1,0).
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= CLEAR_COLOUR;
      vga_plot   <= 1'b1;
      sweep_x    <= 8'd1;
      sweep_y    <= '0;
    end else if (state == CLEAR) begin
      vga_x      <= sweep_x;
      vga_y      <= sweep_y;
      vga_colour <= CLEAR_COLOUR;
      vga_plot   <= 1'b1;
      if (sweep_x == X_LAST) begin
        sweep_x <= '0;
        sweep_y <= (sweep_y == Y_LAST) ? '0 : sweep_y + 7'd1;
      end else begin
        sweep_x <= sweep_x + 8'd1;
      end
    end else if (found) begin
      vga_x      <= lane_x[gidx];
      vga_y      <= lane_y[gidx];
      vga_colour <= lane_c[gidx];
      vga_plot   <= !lane_oob[gidx];
      rr_ptr     <= gidx;
      if (lane_oob[gidx]) oob_err <= 1'b1;
    end else begin
      vga_plot <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: directed steps plus random
// traffic checked against a round-robin/pixel reference model.

module tb_pixel_write_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic [2:0]  req_valid = '0;
  logic [23:0] req_x = '0;
  logic [20:0] req_y = '0;
  logic [8:0]  req_colour = '0;
  logic [2:0]  req_ready;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        oob_err;

  int passed = 0;
  int total  = 0;

  // Reference model: pending requests and the expected output register.
  bit pend[3];
  int px[3], py[3], pc[3];
  int m_last = 2;
  bit m_oob  = 0;
  bit m_plot = 0;
  int ex = 0, ey = 0, ec = 0;

  always #5 clk = ~clk;

  pixel_write_arbiter dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(clear_busy),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .req_ready(req_ready), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .oob_err(oob_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    for (int i = 0; i < 3; i++) begin
      req_valid[i]          = pend[i];
      req_x[8*i +: 8]       = 8'(px[i]);
      req_y[7*i +: 7]       = 7'(py[i]);
      req_colour[3*i +: 3]  = 3'(pc[i]);
    end
  endtask

  task automatic new_req(input int i, input bit allow_oob);
    pend[i] = 1;
    px[i]   = allow_oob ? $urandom_range(0, 170) : $urandom_range(0, 159);
    py[i]   = allow_oob ? $urandom_range(0, 127) : $urandom_range(0, 119);
    pc[i]   = $urandom_range(0, 7);
  endtask

  task automatic run_cycle(input string tag);
    int         g;
    int         cand;
    logic [2:0] er;
    bit         drop;
    g  = -1;
    er = '0;
    apply();
    #1;
    // The winner is the first pending requester counting up from the last winner.
    for (int k = 1; k <= 3; k++) begin
      cand = (m_last + k) % 3;
      if (g < 0 && pend[cand]) g = cand;
    end
    if (g >= 0) er[g] = 1'b1;
    chk({tag, " ready"}, req_ready, er);
    tick();
    if (g >= 0) begin
      drop   = (px[g] >= 160) || (py[g] >= 120);
      m_plot = !drop;
      if (drop) m_oob = 1;
      ex = px[g]; ey = py[g]; ec = pc[g];
      pend[g] = 0;
      m_last  = g;
    end else begin
      m_plot = 0;
    end
    chk({tag, " plot"}, vga_plot, m_plot);
    chk({tag, " oob"}, oob_err, m_oob);
    if (m_plot) begin
      chk({tag, " x"}, vga_x, ex);
      chk({tag, " y"}, vga_y, ey);
      chk({tag, " colour"}, vga_colour, ec);
    end
  endtask

  initial begin
    int bad, plots, busy_bad;
    for (int i = 0; i < 3; i++) begin pend[i] = 0; px[i] = 0; py[i] = 0; pc[i] = 0; end

    // Reset with all requesters valid: ready must stay low.
    pend[0] = 1; pend[1] = 1; pend[2] = 1;
    apply();
    #2 reset_n = 1'b0;
    #1;
    chk("rst plot", vga_plot, 0);
    chk("rst x", vga_x, 0);
    chk("rst y", vga_y, 0);
    chk("rst colour", vga_colour, 0);
    chk("rst busy", clear_busy, 0);
    chk("rst oob", oob_err, 0);
    chk("rst ready", req_ready, 0);
    tick(); tick();
    chk("rst ready held", req_ready, 0);
    for (int i = 0; i < 3; i++) pend[i] = 0;
    @(negedge clk) reset_n = 1'b1;

    // First pixel from requester 0, then an idle cycle.
    pend[0] = 1; px[0] = 80; py[0] = 60; pc[0] = 7;
    run_cycle("first");
    run_cycle("first idle");

    // All three held valid: round-robin rotation.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 3; i++) if (!pend[i]) new_req(i, 0);
      run_cycle("fair");
    end
    for (int i = 0; i < 3; i++) pend[i] = 0;

    // Random in-range traffic; oob_err must stay clear.
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 3; i++) if (!pend[i] && ($urandom_range(0, 1) == 1)) new_req(i, 0);
      run_cycle("rand");
    end
    for (int i = 0; i < 3; i++) pend[i] = 0;
    run_cycle("drain");

    // Clear wins over a simultaneous request; second clear pulse is ignored.
    pend[1] = 1; px[1] = 5; py[1] = 6; pc[1] = 3;
    clear_req = 1'b1;
    apply();
    #1;
    chk("clr ready", req_ready, 0);
    chk("clr busy pre", clear_busy, 0);
    tick();
    clear_req = 1'b0;
    bad = 0; plots = 0; busy_bad = 0;
    for (int i = 0; i < 19200; i++) begin
      if (i > 0) begin
        if (clear_busy !== 1'b1 || req_ready !== 3'b000) busy_bad++;
        if (i == 5000) clear_req = 1'b1;
        if (i == 5001) clear_req = 1'b0;
        tick();
      end
      if (vga_plot === 1'b1) plots++;
      if (vga_x !== 8'(i % 160) || vga_y !== 7'(i / 160) || vga_colour !== 3'd0 || vga_plot !== 1'b1)
        bad++;
    end
    chk("clr pixel errors", bad, 0);
    chk("clr plot count", plots, 19200);
    chk("clr busy/ready errors", busy_bad, 0);
    chk("clr busy done", clear_busy, 0);
    m_plot = 1;
    run_cycle("post clear");
    run_cycle("post clear idle");

    // Random traffic including out-of-range pixels.
    for (int n = 0; n < 50; n++) begin
      for (int i = 0; i < 3; i++) if (!pend[i] && ($urandom_range(0, 1) == 1)) new_req(i, 1);
      run_cycle("rand oob");
    end
    for (int i = 0; i < 3; i++) pend[i] = 0;
    run_cycle("drain2");

    // Second clear, interrupted by reset at sweep pixel (37,5).
    clear_req = 1'b1;
    apply();
    tick();
    clear_req = 1'b0;
    for (int i = 1; i <= 837; i++) tick();
    chk("sweep x", vga_x, 37);
    chk("sweep y", vga_y, 5);
    chk("sweep busy", clear_busy, 1);
    pend[0] = 1; px[0] = 12; py[0] = 34; pc[0] = 5;
    pend[2] = 1; px[2] = 100; py[2] = 90; pc[2] = 2;
    apply();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst plot", vga_plot, 0);
    chk("midrst x", vga_x, 0);
    chk("midrst y", vga_y, 0);
    chk("midrst colour", vga_colour, 0);
    chk("midrst busy", clear_busy, 0);
    chk("midrst oob", oob_err, 0);
    chk("midrst ready", req_ready, 0);
    m_last = 2; m_oob = 0; m_plot = 0;
    @(negedge clk) reset_n = 1'b1;
    run_cycle("after rst");
    run_cycle("after rst 2");

    // Out-of-range request is accepted but dropped; flag stays sticky.
    pend[1] = 1; px[1] = 160; py[1] = 10; pc[1] = 4;
    run_cycle("oob");
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 3; i++) if (!pend[i] && ($urandom_range(0, 1) == 1)) new_req(i, 0);
      run_cycle("oob sticky");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
